seq_multiplier_param: RTL and testbench

Parametrised sequential shift-add multiplier: the next generation of the team's fixed 16x16 sequential multiplier. It multiplies two WIDTH-bit operands in WIDTH iterations using one adder, and adds a synchronous reset, a busy/done handshake, operand latching at start, and optional signed mode. It sits in the datapath wherever a low-area multiply is acceptable at the cost of latency.

---
 rtl/seq_multiplier_param.sv | 132 +++++++++++++
 tb/tb_seq_multiplier_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: parametrised shift-add sequential multiplier.
// One WIDTH+1 bit adder is reused for WIDTH iterations. Operands are
// latched at start, and a busy/done handshake frames each multiply.
// Optional signed mode is compiled in when SEQ_MUL_SIGNED_EN is defined.
// Signed mode multiplies the operand magnitudes and negates the result
// at the end when the operand signs differ.
module seq_multiplier_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mc_r;
  logic [2*WIDTH:0]     acc;
  logic [CW-1:0]        cnt;

  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH:0]     acc_next;
  logic [WIDTH-1:0]     mc_in;
  logic [WIDTH-1:0]     mp_in;
  logic [2*WIDTH-1:0]   prod_fin;

`ifdef SEQ_MUL_SIGNED_EN
  logic                 sign_in;
  logic                 sign_r;

  // Convert operands to magnitudes at accept time when signed mode is requested
  always_comb begin
    sign_in = signed_mode & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
    mc_in   = (signed_mode && mcand[WIDTH-1])  ? -mcand  : mcand;
    mp_in   = (signed_mode && mplier[WIDTH-1]) ? -mplier : mplier;
  end
`else
  // Unsigned build: operands are used as-is
  always_comb begin
    mc_in = mcand;
    mp_in = mplier;
  end
`endif

  // One iteration: conditional add into the upper half (carry kept), then shift right
  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH];
    if (acc[0]) begin
      upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mc_r};
    end
    acc_next = {1'b0, upper_sum, acc[WIDTH-1:1]};
  end

`ifdef SEQ_MUL_SIGNED_EN
  // Final product, negated when the latched operand signs differed
  always_comb begin
    prod_fin = sign_r ? -acc_next[2*WIDTH-1:0] : acc_next[2*WIDTH-1:0];
  end
`else
  // Final product is the low 2*WIDTH bits after the last shift
  always_comb begin
    prod_fin = acc_next[2*WIDTH-1:0];
  end
`endif

  // Control FSM and datapath registers; reset discards any in-flight multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      cnt     <= '0;
      mc_r    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      sign_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mc_r  <= mc_in;
            acc   <= {{(WIDTH+1){1'b0}}, mp_in};
            cnt   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sign_r <= sign_in;
`endif
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            product <= prod_fin;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// tb_seq_multiplier_param: randomized self-checking bench for seq_multiplier_param.
// Covers signed operation when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_multiplier_param;

  localparam int W  = 16;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signedMode;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] expProduct;

  seq_multiplier_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mcand       (mcand),
    .mplier      (mplier),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_mode (signedMode),
`endif
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer multiplication of the operands as numbers
  function automatic logic [PW-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    longint sa;
    longint sb;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({1'b0, a});
      sb = longint'({1'b0, b});
    end
    return PW'(sa * sb);
  endfunction

  // One multiply: accept, optional ignored start pulse, latency/busy/product/hold checks
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                               input int pulseAt, input string tag);
    int            lat;
    int            busyCnt;
    bit            holdOk;
    bit            seen;
    logic [PW-1:0] expVal;
    logic [PW-1:0] got;
    expVal = refProduct(a, b, sm);
    got    = '0;
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b; signedMode = sm;
    @(posedge clk); #1;
    start = 1'b0;
    mcand = W'($urandom); mplier = W'($urandom); signedMode = 1'($urandom);
    busyCnt = busy ? 1 : 0;
    lat = -1; holdOk = 1'b1; seen = 1'b0;
    for (int i = 1; i <= W + 8 && !seen; i++) begin
      if (i == pulseAt) begin
        start = 1'b1; mcand = W'($urandom); mplier = W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busyCnt++;
      if (done) begin
        seen = 1'b1; lat = i; got = product;
      end else if (product !== expProduct) begin
        holdOk = 1'b0;
      end
    end
    checkOutput({tag, " latency"}, lat, W);
    checkOutput({tag, " product"}, got, expVal);
    checkOutput({tag, " held"}, holdOk, 1);
    checkOutput({tag, " busy cycles"}, busyCnt, W + 1);
    @(posedge clk); #1;
    checkOutput({tag, " idle busy/done"}, {busy, done}, 2'b00);
    expProduct = expVal;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           doneAt[$];
    bit           doneSeen;

    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0; signedMode = 1'b0;
    expProduct = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset product", product, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 0, "max");
    checkOutput("max literal", product, 32'hFFFE0001);
    applyStimulus(16'h0000, 16'h1234, 1'b0, 0, "zero");
    checkOutput("zero literal", product, 32'h00000000);
    applyStimulus(16'h0003, 16'h0005, 1'b0, 0, "small");
    checkOutput("small literal", product, 32'h0000000F);
    applyStimulus(16'h1357, 16'h2468, 1'b0, 5, "ignore start");

    // Start held high: results back to back, W+2 cycles apart
    ra = 16'hBEEF; rb = 16'h0123;
    @(negedge clk);
    start = 1'b1; mcand = ra; mplier = rb; signedMode = 1'b0;
    for (int c = 0; c < 3 * (W + 2); c++) begin
      @(posedge clk); #1;
      if (done) doneAt.push_back(c);
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("held start count", doneAt.size(), 3);
    if (doneAt.size() == 3) begin
      checkOutput("held start first", doneAt[0], W);
      checkOutput("held start spacing1", doneAt[1] - doneAt[0], W + 2);
      checkOutput("held start spacing2", doneAt[2] - doneAt[1], W + 2);
    end
    checkOutput("held start product", product, refProduct(ra, rb, 1'b0));
    expProduct = refProduct(ra, rb, 1'b0);
    repeat (4) @(posedge clk);

    // Reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; mcand = 16'h7777; mplier = 16'h5555; signedMode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset product", product, 0);
    @(negedge clk);
    rst = 1'b0;
    expProduct = '0;
    doneSeen = 1'b0;
    for (int c = 0; c < W + 4; c++) begin
      @(posedge clk); #1;
      if (done) doneSeen = 1'b1;
    end
    checkOutput("midreset no done", doneSeen, 0);
    applyStimulus(16'h00C8, 16'h0101, 1'b0, 0, "after reset");

`ifdef SEQ_MUL_SIGNED_EN
    applyStimulus(16'hFFFD, 16'h0005, 1'b1, 0, "signed neg");
    checkOutput("signed neg literal", product, 32'hFFFFFFF1);
    applyStimulus(16'h8000, 16'h8000, 1'b1, 0, "signed min");
    checkOutput("signed min literal", product, 32'h40000000);
    applyStimulus(16'hFFFD, 16'h0005, 1'b0, 0, "signed off");
`endif

    // Randomized vectors, with occasional extreme operands and ignored start pulses
    for (int n = 0; n < 150; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '1;
        2: ra = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
`ifdef SEQ_MUL_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      applyStimulus(ra, rb, rs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
